// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the pins, frames bytes, and turns make/break
// scan codes for the piano keys into a held ASCII code with a press strobe.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [6:0] ascii,
    output logic       key_valid,
    output logic       key_strobe,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_prev;
    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift, r_byte;
    logic          r_par, r_byte_vld, r_err;
    logic [TW-1:0] r_tcnt;
    logic          r_brk, r_ext;

    logic          w_fall, w_dat, w_timeout;
    logic          w_map_vld;
    logic [6:0]    w_map_code;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            if (r_state == S_IDLE || w_fall) r_tcnt <= '0;
            else                             r_tcnt <= r_tcnt + 1'b1;

            if (w_timeout) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        // A high start bit is treated as line noise.
                        if (!w_dat) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {w_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= w_dat;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (w_dat && (^{r_shift, r_par})) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_map_vld  = 1'b1;
        w_map_code = 7'd0;
        case (r_byte)
            8'h1C: w_map_code = 7'd65;
            8'h1B: w_map_code = 7'd83;
            8'h23: w_map_code = 7'd68;
            8'h2B: w_map_code = 7'd70;
            8'h34: w_map_code = 7'd71;
            8'h33: w_map_code = 7'd72;
            8'h3B: w_map_code = 7'd74;
            8'h1D: w_map_code = 7'd87;
            8'h24: w_map_code = 7'd69;
            8'h2C: w_map_code = 7'd84;
            8'h35: w_map_code = 7'd89;
            8'h3C: w_map_code = 7'd85;
            default: w_map_vld = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            ascii      <= '0;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= r_err;
            if (r_err) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (r_byte_vld) begin
                if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (!r_ext && w_map_vld) begin
                        if (r_brk) begin
                            // Releasing an older key must not silence the newer one.
                            if (w_map_code == ascii) begin
                                ascii     <= '0;
                                key_valid <= 1'b0;
                            end
                        end else if (!key_valid || w_map_code != ascii) begin
                            ascii      <= w_map_code;
                            key_valid  <= 1'b1;
                            key_strobe <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on the pins and checks the
// held key, strobe/error pulse counts, latency, timeout and reset behaviour.
module tb_ps2_key_decoder;
    localparam int TMO  = 1000;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [6:0] ascii;
    logic       key_valid, key_strobe, frame_err;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int collide_cnt = 0;
    int s0, e0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .ascii(ascii), .key_valid(key_valid), .key_strobe(key_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (key_strobe) strobe_cnt++;
            if (frame_err) err_cnt++;
            if (key_strobe && frame_err) collide_cnt++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_neg(HALF);
        ps2_clk = 1'b0;
        wait_neg(HALF);
        ps2_clk = 1'b1;
    endtask

    // Everything up to and including the falling edge of the stop bit.
    task automatic frame_to_stop(input logic [7:0] b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        ps2_dat = 1'b1;
        wait_neg(HALF);
        ps2_clk = 1'b0;
    endtask

    task automatic finish_stop();
        wait_neg(HALF);
        ps2_clk = 1'b1;
        wait_neg(30);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par_flip);
        frame_to_stop(b, par_flip);
        finish_stop();
    endtask

    initial begin
        wait_neg(3);
        check("rst_ascii", ascii, 0);
        check("rst_valid", key_valid, 0);
        check("rst_strobe", key_strobe, 0);
        check("rst_err", frame_err, 0);
        resetn = 1'b1;
        wait_neg(5);

        // 1: exact latency and one-clock strobe
        frame_to_stop(8'h1C, 1'b0);
        wait_neg(3);
        check("t1_pre_valid", key_valid, 0);
        wait_neg(1);
        check("t1_ascii", ascii, 65);
        check("t1_valid", key_valid, 1);
        check("t1_strobe_hi", key_strobe, 1);
        wait_neg(1);
        check("t1_strobe_lo", key_strobe, 0);
        finish_stop();
        check("t1_strobe_cnt", strobe_cnt, 1);

        // 2: typematic repeat then release
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("t2_rep_strobes", strobe_cnt, 1);
        check("t2_rep_ascii", ascii, 65);
        send_byte(8'hF0, 1'b0);
        check("t2_f0_noop", ascii, 65);
        send_byte(8'h1C, 1'b0);
        check("t2_rel_ascii", ascii, 0);
        check("t2_rel_valid", key_valid, 0);

        // 3: last pressed wins; stale release ignored
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1D, 1'b0);
        check("t3_w_ascii", ascii, 87);
        check("t3_strobes", strobe_cnt, 3);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("t3_stale_ascii", ascii, 87);
        check("t3_stale_valid", key_valid, 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        check("t3_rel_ascii", ascii, 0);

        // 4: parity error, then good frame; error clears pending break prefix
        send_byte(8'h1C, 1'b1);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_ascii", ascii, 0);
        check("t4_valid", key_valid, 0);
        send_byte(8'h1B, 1'b0);
        check("t4_s_ascii", ascii, 83);
        s0 = strobe_cnt;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1B, 1'b1);
        check("t4_err_cnt2", err_cnt, 2);
        send_byte(8'h1B, 1'b0);
        check("t4_brk_cleared", ascii, 83);
        check("t4_no_strobe", strobe_cnt, s0);

        // 5: timeout mid-frame, then recovery
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        e0 = err_cnt;
        wait_neg(TMO / 2);
        check("t5_no_early_err", err_cnt, e0);
        wait_neg(TMO);
        check("t5_timeout_err", err_cnt, e0 + 1);
        send_byte(8'h23, 1'b0);
        check("t5_d_ascii", ascii, 68);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h23, 1'b0);
        check("t5_rel", ascii, 0);

        // 6: extended and unmapped codes ignored; reset mid-frame
        s0 = strobe_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("t6_ext_ascii", ascii, 0);
        send_byte(8'h15, 1'b0);
        check("t6_unmap_ascii", ascii, 0);
        check("t6_no_strobe", strobe_cnt, s0);
        send_byte(8'h1C, 1'b0);
        check("t6_held", ascii, 65);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        resetn = 1'b0;
        #1;
        check("t6_rst_ascii", ascii, 0);
        check("t6_rst_valid", key_valid, 0);
        ps2_dat = 1'b1;
        wait_neg(3);
        resetn = 1'b1;
        wait_neg(5);
        send_byte(8'h1B, 1'b0);
        check("t6_after_rst", ascii, 83);
        check("t6_err_total", err_cnt, 3);
        check("no_collide", collide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
